// File: rtl/aud_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aud_cap_pkg
// Brief    : Shared types and constants for the I2S capture engine: the
//            control FSM state encoding, the channel-mode codes and the
//            frame-selection helper.
// Revision : 1.0 - initial release
// ============================================================================
package aud_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAUSE = 2'd3
  } cap_state_e;

  localparam int CH_RIGHT  = 0;
  localparam int CH_LEFT   = 1;
  localparam int CH_STEREO = 2;

  // A frame start is taken when its channel matches the mode. In stereo a
  // right frame is only taken directly after a left word (pair alignment).
  function automatic logic ch_selected(input int mode, input logic lrc, input logic pair);
    logic sel;
    case (mode)
      CH_RIGHT: sel = lrc;
      CH_LEFT:  sel = ~lrc;
      default:  sel = ~lrc | pair;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aud_i2s_deser.sv
`default_nettype none
// ============================================================================
// Module   : aud_i2s_deser
// Brief    : I2S deserialiser. Detects LR-clock transitions, counts bits and
//            places each serial bit MSB-first into the word register. Emits a
//            combinational word_valid on the edge that samples the last bit,
//            or on a frame start that cuts a word short (LSBs stay zero).
// Revision : 1.0 - initial release
// ============================================================================
module aud_i2s_deser #(
  parameter int DATA_W = 16
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_run,
  input  logic              i_load,
  output logic              o_frame_start,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word,
  output logic              o_ch
);

  localparam int c_cnt_w = $clog2(DATA_W + 1);

  logic               r_lrc_q;
  logic [c_cnt_w-1:0] r_cnt;
  logic [DATA_W-1:0]  r_word;
  logic               r_ch;
  logic               w_fs;
  logic               w_last;

  assign w_fs          = i_lrc ^ r_lrc_q;
  assign w_last        = i_run & ~w_fs & (r_cnt == c_cnt_w'(1));
  assign o_frame_start = w_fs;
  assign o_word_valid  = w_last | (i_run & w_fs);
  // The last bit is merged in combinationally so the word is written on the
  // same edge that samples it.
  assign o_word        = w_last ? {r_word[DATA_W-1:1], i_data} : r_word;
  assign o_ch          = r_ch;

  // LR edge history, bit countdown and bit placement (count = bits remaining).
  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrc_q <= 1'b0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_ch    <= 1'b0;
    end else begin
      r_lrc_q <= i_lrc;
      if (i_load) begin
        r_word <= '0;
        r_cnt  <= c_cnt_w'(DATA_W);
        r_ch   <= i_lrc;
      end else if (i_run && !w_fs && (r_cnt != '0)) begin
        for (int b = 0; b < DATA_W; b++) begin
          if (r_cnt == c_cnt_w'(b + 1)) r_word[b] <= i_data;
        end
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aud_capture_engine.sv
`default_nettype none
// ============================================================================
// Module   : aud_capture_engine
// Brief    : I2S capture engine. Deserialises codec ADC frames on the falling
//            edge of the bit clock and issues one SRAM write per captured
//            word, under start/pause/stop control.
// Config   : AUD_CAP_AUTOSTOP_EN - when defined, capture stops after the
//            write to address MAX_WORDS-1 and raises o_full; otherwise the
//            write pointer wraps (ring buffer) and o_full is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module aud_capture_engine #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int MAX_WORDS = 2**ADDR_W,
  parameter int CH_MODE   = 0
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W:0]   o_len,
  output logic              o_busy,
  output logic              o_full
);

  import aud_cap_pkg::*;

  localparam int c_len_w = ADDR_W + 1;

  cap_state_e          r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_we;
  logic [c_len_w-1:0]  r_len;
  logic                r_pair;

  logic                w_cmd;
  logic                w_run;
  logic                w_fs;
  logic                w_wv;
  logic [DATA_W-1:0]   w_word;
  logic                w_ch;
  logic                w_pair_now;
  logic                w_load;
  logic                w_last_addr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [c_len_w-1:0]  w_len_nxt;

  // Stop/pause suppress both shifting and writing on the edge they are seen.
  assign w_cmd       = i_stop | i_pause;
  assign w_run       = (r_state == ST_SHIFT) & ~w_cmd;
  // A left word written on this very edge already qualifies the right frame.
  assign w_pair_now  = w_wv ? ~w_ch : r_pair;
  assign w_load      = ~w_cmd & w_fs & ch_selected(CH_MODE, i_lrc, w_pair_now) &
                       ((r_state == ST_ARM) | (r_state == ST_SHIFT));
  assign w_last_addr = (r_ptr == ADDR_W'(MAX_WORDS - 1));
  assign w_ptr_nxt   = w_last_addr ? '0 : r_ptr + ADDR_W'(1);
  assign w_len_nxt   = (r_len == c_len_w'(MAX_WORDS)) ? r_len : r_len + c_len_w'(1);

  aud_i2s_deser #(
    .DATA_W (DATA_W)
  ) u_deser (
    .i_bclk        (i_bclk),
    .i_rst_n       (i_rst_n),
    .i_lrc         (i_lrc),
    .i_data        (i_data),
    .i_run         (w_run),
    .i_load        (w_load),
    .o_frame_start (w_fs),
    .o_word_valid  (w_wv),
    .o_word        (w_word),
    .o_ch          (w_ch)
  );

`ifdef AUD_CAP_AUTOSTOP_EN
  logic r_full;
  assign o_full = r_full;
`else
  assign o_full = 1'b0;
`endif

  // Control FSM with write strobe, address, data and length registers.
  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_len   <= '0;
      r_pair  <= 1'b0;
`ifdef AUD_CAP_AUTOSTOP_EN
      r_full  <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            r_state <= ST_ARM;
            r_ptr   <= '0;
            r_len   <= '0;
            r_pair  <= 1'b0;
`ifdef AUD_CAP_AUTOSTOP_EN
            r_full  <= 1'b0;
`endif
          end
        end
        ST_ARM, ST_SHIFT: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
          end else if (i_pause) begin
            r_state <= ST_PAUSE;
            r_pair  <= 1'b0;
          end else if (w_wv) begin
            r_we    <= 1'b1;
            r_addr  <= r_ptr;
            r_data  <= w_word;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
            r_pair  <= ~w_ch;
            r_state <= w_load ? ST_SHIFT : ST_ARM;
`ifdef AUD_CAP_AUTOSTOP_EN
            if (w_last_addr) begin
              r_state <= ST_IDLE;
              r_full  <= 1'b1;
            end
`endif
          end else if (w_load) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_PAUSE: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
          end else if (i_start || i_pause) begin
            r_state <= ST_ARM;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_address = r_addr;
  assign o_data    = r_data;
  assign o_we      = r_we;
  assign o_len     = r_len;
  assign o_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aud_capture_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_capture_engine
// Brief    : Self-checking bench for aud_capture_engine. Four instances share
//            the serial and command inputs: u0 (right-only, 16 bit), u1
//            (stereo), u2 (depth 4) and u3 (24 bit). A per-frame vector table
//            drives u0; hand-written sequences cover the remaining cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aud_capture_engine;

`ifdef AUD_CAP_AUTOSTOP_EN
  localparam bit c_auto = 1'b1;
`else
  localparam bit c_auto = 1'b0;
`endif

  logic bclk = 1'b0;
  logic rst_n = 1'b0;
  logic lrc = 1'b0, sdata = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;

  logic [19:0] a0, a1;  logic [15:0] d0, d1;  logic [20:0] l0, l1;
  logic [1:0]  a2;      logic [15:0] d2;      logic [2:0]  l2;
  logic [19:0] a3;      logic [23:0] d3;      logic [20:0] l3;
  logic we0, we1, we2, we3, bz0, bz1, bz2, bz3, fu0, fu1, fu2, fu3;

  always #5 bclk = ~bclk;

  aud_capture_engine #(.DATA_W(16), .ADDR_W(20), .CH_MODE(0)) u0 (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata), .i_start(start),
    .i_pause(pause), .i_stop(stop), .o_address(a0), .o_data(d0), .o_we(we0),
    .o_len(l0), .o_busy(bz0), .o_full(fu0));
  aud_capture_engine #(.DATA_W(16), .ADDR_W(20), .CH_MODE(2)) u1 (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata), .i_start(start),
    .i_pause(pause), .i_stop(stop), .o_address(a1), .o_data(d1), .o_we(we1),
    .o_len(l1), .o_busy(bz1), .o_full(fu1));
  aud_capture_engine #(.DATA_W(16), .ADDR_W(2), .MAX_WORDS(4), .CH_MODE(0)) u2 (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata), .i_start(start),
    .i_pause(pause), .i_stop(stop), .o_address(a2), .o_data(d2), .o_we(we2),
    .o_len(l2), .o_busy(bz2), .o_full(fu2));
  aud_capture_engine #(.DATA_W(24), .ADDR_W(20), .CH_MODE(0)) u3 (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata), .i_start(start),
    .i_pause(pause), .i_stop(stop), .o_address(a3), .o_data(d3), .o_we(we3),
    .o_len(l3), .o_busy(bz3), .o_full(fu3));

  int n_vec = 0;
  int n_err = 0;
  int wn[4];
  logic [31:0] wa[4], wd[4];

  // Write monitor: samples on the rising edge, opposite to the DUT's edge.
  always @(posedge bclk) begin
    if (we0) begin wn[0] = wn[0] + 1; wa[0] = 32'(a0); wd[0] = 32'(d0); end
    if (we1) begin wn[1] = wn[1] + 1; wa[1] = 32'(a1); wd[1] = 32'(d1); end
    if (we2) begin wn[2] = wn[2] + 1; wa[2] = 32'(a2); wd[2] = 32'(d2); end
    if (we3) begin wn[3] = wn[3] + 1; wa[3] = 32'(a3); wd[3] = 32'(d3); end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) wn[k] = 0;
  endtask

  // One bit-clock edge: inputs applied, falling edge consumes them.
  task automatic step(input logic l, input logic d, input logic st, input logic pa, input logic sp);
    lrc = l; sdata = d; start = st; pause = pa; stop = sp;
    @(negedge bclk); @(posedge bclk); #1;
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  // Frame-start edge (delay slot) followed by nbits data bits, MSB first.
  task automatic frame(input logic ch, input int nbits, input logic [31:0] w);
    step(ch, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = nbits - 1; i >= 0; i--) step(ch, w[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lrc = 1'b0; sdata = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr();
  endtask

  typedef struct {
    logic        ch;
    int          nbits;
    logic [31:0] word;
    int          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_len;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 16, 32'hA5C3,  1, 0, 32'hA5C3, 1};
    tbl[1] = '{1'b0, 16, 32'hFFFF,  0, 0, 32'hA5C3, 1};
    tbl[2] = '{1'b1, 16, 32'h1234,  1, 1, 32'h1234, 2};
    tbl[3] = '{1'b0, 16, 32'h0F0F,  0, 1, 32'h1234, 2};
    tbl[4] = '{1'b1,  8, 32'h005A,  0, 1, 32'h1234, 2};
    tbl[5] = '{1'b0, 16, 32'hFFFF,  1, 2, 32'h5A00, 3};
    tbl[6] = '{1'b1, 20, 32'h9ABCD, 1, 3, 32'h9ABC, 4};
    tbl[7] = '{1'b0, 16, 32'h0000,  0, 3, 32'h9ABC, 4};
    tbl[8] = '{1'b1, 16, 32'hFFFF,  1, 4, 32'hFFFF, 5};
    clr();

    // Reset state
    @(posedge bclk); #1;
    chk("rst addr", 32'(a0), 0);  chk("rst data", 32'(d0), 0);
    chk("rst we", 32'(we0), 0);   chk("rst len", 32'(l0), 0);
    chk("rst busy", 32'(bz0), 0); chk("rst full", 32'(fu0), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Right-only capture, frame table
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("start busy", 32'(bz0), 1);
    for (int i = 0; i < 9; i++) begin
      clr();
      frame(tbl[i].ch, tbl[i].nbits, tbl[i].word);
      chk($sformatf("v%0d we", i), 32'(wn[0]), 32'(tbl[i].exp_we));
      chk($sformatf("v%0d addr", i), 32'(a0), tbl[i].exp_addr);
      chk($sformatf("v%0d data", i), 32'(d0), tbl[i].exp_data);
      chk($sformatf("v%0d len", i), 32'(l0), tbl[i].exp_len);
    end

    // Stereo: start mid right frame, pairs begin on the left frame
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("st pre we", 32'(wn[1]), 0);
    frame(1'b0, 16, 32'h0001);
    chk("st L we", 32'(wn[1]), 1);  chk("st L addr", wa[1], 0);  chk("st L data", wd[1], 32'h0001);
    frame(1'b1, 16, 32'h0002);
    chk("st R we", 32'(wn[1]), 2);  chk("st R addr", wa[1], 1);  chk("st R data", wd[1], 32'h0002);
    chk("st len", 32'(l1), 2);

    // Pause mid-word, resume with start
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b1, 16, 32'hA5C3);
    frame(1'b0, 16, 32'h0);
    clr();
    frame(1'b1, 8, 32'hFF);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pause busy", 32'(bz0), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("paused busy", 32'(bz0), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("resume busy", 32'(bz0), 1);
    chk("pause no we", 32'(wn[0]), 0);
    frame(1'b0, 16, 32'h0);
    frame(1'b1, 16, 32'h1234);
    chk("resume we", 32'(wn[0]), 1);  chk("resume addr", 32'(a0), 1);
    chk("resume data", 32'(d0), 32'h1234);  chk("resume len", 32'(l0), 2);

    // Stop and start together in SHIFT
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b1, 16, 32'h1111);
    frame(1'b0, 16, 32'h0);
    frame(1'b1, 16, 32'h2222);
    frame(1'b0, 16, 32'h0);
    clr();
    frame(1'b1, 5, 32'h1F);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("stop busy", 32'(bz0), 0);  chk("stop we", 32'(wn[0]), 0);
    chk("stop addr", 32'(a0), 1);   chk("stop len", 32'(l0), 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart len", 32'(l0), 0); chk("restart busy", 32'(bz0), 1);
    frame(1'b0, 16, 32'h0);
    frame(1'b1, 16, 32'h0BAD);
    chk("restart addr", 32'(a0), 0);  chk("restart data", 32'(d0), 32'h0BAD);
    chk("restart len1", 32'(l0), 1);

    // Depth 4, six right frames
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      clr();
      frame(1'b1, 16, 32'h1000 + 32'(k));
      chk($sformatf("d4 f%0d we", k), 32'(wn[2]), (!c_auto || k < 4) ? 1 : 0);
      chk($sformatf("d4 f%0d addr", k), 32'(a2), c_auto ? ((k < 4) ? k : 3) : (k % 4));
      chk($sformatf("d4 f%0d data", k), 32'(d2),
          32'h1000 + 32'(c_auto ? ((k < 4) ? k : 3) : k));
      chk($sformatf("d4 f%0d len", k), 32'(l2), (k < 3) ? (k + 1) : 4);
      frame(1'b0, 16, 32'h0);
    end
    chk("d4 full", 32'(fu2), c_auto ? 1 : 0);
    chk("d4 busy", 32'(bz2), c_auto ? 0 : 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("d4 full clr", 32'(fu2), 0);
    chk("d4 busy2", 32'(bz2), 1);
    frame(1'b1, 16, 32'h7777);
    chk("d4 next addr", 32'(a2), c_auto ? 0 : 2);
    chk("d4 next data", 32'(d2), 32'h7777);
    chk("d4 next len", 32'(l2), c_auto ? 1 : 4);

    // 24-bit word from a 16-bit frame, then async reset mid-word
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b1, 16, 32'hBEEF);
    chk("w24 no early we", 32'(wn[3]), 0);
    frame(1'b0, 16, 32'h0);
    chk("w24 we", 32'(wn[3]), 1);
    chk("w24 data", 32'(d3), 32'hBEEF00);
    chk("w24 addr", 32'(a3), 0);
    chk("w24 len", 32'(l3), 1);
    frame(1'b1, 5, 32'h15);
    rst_n = 1'b0;
    #1;
    chk("arst addr", 32'(a3), 0);  chk("arst data", 32'(d3), 0);
    chk("arst we", 32'(we3), 0);   chk("arst len", 32'(l3), 0);
    chk("arst busy", 32'(bz3), 0); chk("arst full", 32'(fu3), 0);
    clr();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arst no we", 32'(wn[3]), 0);
    chk("arst idle", 32'(bz3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
